// File: rtl/dht11_pkg.sv
// Shared DHT11 sampler types: FSM states, frame geometry and byte lookup.
// Frame bytes arrive MSB-first, so byte 0 (RH integer) sits in the top 8 bits.
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    REL,
    RESP_L,
    RESP_H,
    BIT_L,
    BIT_H,
    CHECK
  } state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  localparam int FRAME_BITS = 40;
  localparam int RH_INT_IDX = 0;
  localparam int RH_DEC_IDX = 1;
  localparam int T_INT_IDX  = 2;
  localparam int T_DEC_IDX  = 3;
  localparam int SUM_IDX    = 4;

  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] frame, input int idx);
    return frame[FRAME_BITS-1-8*idx -: 8];
  endfunction

endpackage

// File: rtl/dht11_sampler_if.sv
// Pad and result signals of the DHT11 sampler; master = sampler, slave = pad/LCD side.
// Results carry no backpressure: data_valid is a fire-and-forget one-cycle strobe.
interface dht11_sampler_if;
  import dht11_pkg::*;

  logic       dht_in;
  logic       dht_drive_low;
  logic [3:0] humidity10;
  logic [3:0] humidity0;
  logic [3:0] temperature10;
  logic [3:0] temperature0;
  logic       data_valid;
  logic       err;
  logic       busy;

  modport master (
    input  dht_in,
    output dht_drive_low, humidity10, humidity0, temperature10, temperature0,
    output data_valid, err, busy
  );

  modport slave (
    output dht_in,
    input  dht_drive_low, humidity10, humidity0, temperature10, temperature0,
    input  data_valid, err, busy
  );

endinterface

// File: rtl/dht11_sampler_bin2bcd99.sv
// bin2bcd99: 8-bit binary to two BCD digits, saturating at 99.
// Purely combinational, zero latency, no backpressure.
module bin2bcd99
  import dht11_pkg::*;
(
  input  logic [7:0] bin,
  output bcd_t       bcd
);

  logic [7:0] tens;

  always_comb begin
    tens = '0;
    bcd  = '{tens: 4'd9, ones: 4'd9};
    if (bin <= 8'd99) begin
      tens     = bin / 8'd10;
      bcd.tens = tens[3:0];
      bcd.ones = 4'(bin - tens * 8'd10);
    end
  end

endmodule

// File: rtl/dht11_sampler.sv
// dht11_sampler: periodic DHT11 single-wire master; decodes 40 bits and publishes BCD RH/T.
// Digits land one cycle after CHECK; no backpressure, data_valid is a one-cycle strobe.
module dht11_sampler #(
  parameter int CYCLES_PER_US  = 1,
  parameter int POLL_US        = 2000000,
  parameter int START_LOW_US   = 18000,
  parameter int BIT1_THRESH_US = 40,
  parameter int TIMEOUT_US     = 200
) (
  input logic             clk,
  input logic             rst,
  dht11_sampler_if.master bus
);
  import dht11_pkg::*;

  localparam int          PRE_W        = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [31:0] POLL_LAST    = 32'(POLL_US - 1);
  localparam logic [31:0] START_LAST   = 32'(START_LOW_US - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_US - 1);
  localparam logic [31:0] BIT1_THRESH  = 32'(BIT1_THRESH_US);
  localparam logic [5:0]  LAST_BIT     = 6'(FRAME_BITS - 1);

  state_t                state;
  logic [31:0]           phase;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [5:0]            bit_cnt;
  logic                  drive_q, valid_q, err_q, busy_q;
  bcd_t                  hum_q, temp_q;

  logic [PRE_W-1:0] pre_cnt;
  logic             us_tick;

  assign us_tick = (pre_cnt == PRE_W'(CYCLES_PER_US - 1));

  always_ff @(posedge clk) begin
    if (rst || us_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Sync chain idles high so a released pad never looks like a falling edge after reset.
  logic din_s1, din_s2, din_d, rise, fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_s1 <= 1'b1;
      din_s2 <= 1'b1;
      din_d  <= 1'b1;
    end else begin
      din_s1 <= bus.dht_in;
      din_s2 <= din_s1;
      din_d  <= din_s2;
    end
  end

  assign rise = din_s2 & ~din_d;
  assign fall = ~din_s2 & din_d;

  logic [7:0] rh_int, rh_dec, t_int, t_dec, sum_rx, sum_calc;
  logic       frame_ok;
  bcd_t       rh_bcd, t_bcd;

  assign rh_int   = frame_byte(shift_reg, RH_INT_IDX);
  assign rh_dec   = frame_byte(shift_reg, RH_DEC_IDX);
  assign t_int    = frame_byte(shift_reg, T_INT_IDX);
  assign t_dec    = frame_byte(shift_reg, T_DEC_IDX);
  assign sum_rx   = frame_byte(shift_reg, SUM_IDX);
  assign sum_calc = rh_int + rh_dec + t_int + t_dec;
  assign frame_ok = (sum_calc == sum_rx);

  bin2bcd99 u_rh_bcd (.bin(rh_int), .bcd(rh_bcd));
  bin2bcd99 u_t_bcd  (.bin(t_int),  .bcd(t_bcd));

  logic wait_st, edge_hit, timeout_hit, bit_val;

  always_comb begin
    wait_st  = 1'b0;
    edge_hit = 1'b0;
    case (state)
      REL, RESP_H, BIT_H: begin wait_st = 1'b1; edge_hit = fall; end
      RESP_L, BIT_L:      begin wait_st = 1'b1; edge_hit = rise; end
      default: ;
    endcase
  end

  // An edge arriving on the expiry tick wins over the timeout.
  assign timeout_hit = wait_st && !edge_hit && us_tick && (phase == TIMEOUT_LAST);
  assign bit_val     = (phase >= BIT1_THRESH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      drive_q   <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      hum_q     <= '0;
      temp_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (us_tick) phase <= phase + 32'd1;
      if (timeout_hit) begin
        state  <= IDLE;
        phase  <= '0;
        busy_q <= 1'b0;
        err_q  <= 1'b1;
      end else begin
        case (state)
          IDLE: if (us_tick && phase == POLL_LAST) begin
            state   <= START;
            phase   <= '0;
            bit_cnt <= '0;
            drive_q <= 1'b1;
            busy_q  <= 1'b1;
          end
          START: if (us_tick && phase == START_LAST) begin
            state   <= REL;
            phase   <= '0;
            drive_q <= 1'b0;
          end
          REL:    if (edge_hit) begin state <= RESP_L; phase <= '0; end
          RESP_L: if (edge_hit) begin state <= RESP_H; phase <= '0; end
          RESP_H: if (edge_hit) begin state <= BIT_L;  phase <= '0; end
          BIT_L:  if (edge_hit) begin state <= BIT_H;  phase <= '0; end
          BIT_H: if (edge_hit) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], bit_val};
            bit_cnt   <= bit_cnt + 6'd1;
            phase     <= '0;
            state     <= (bit_cnt == LAST_BIT) ? CHECK : BIT_L;
          end
          CHECK: begin
            state  <= IDLE;
            phase  <= '0;
            busy_q <= 1'b0;
            if (frame_ok) begin
              hum_q   <= rh_bcd;
              temp_q  <= t_bcd;
              valid_q <= 1'b1;
              err_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.dht_drive_low = drive_q;
  assign bus.humidity10    = hum_q.tens;
  assign bus.humidity0     = hum_q.ones;
  assign bus.temperature10 = temp_q.tens;
  assign bus.temperature0  = temp_q.ones;
  assign bus.data_valid    = valid_q;
  assign bus.err           = err_q;
  assign bus.busy          = busy_q;

endmodule
